// File: rtl/bus_arbiter_4_pkg.sv
// Shared types and helpers for the four-requester round-robin bus arbiter.
package arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the search starts one above last_owner and
// wraps upward, so last_owner itself is considered last.
module rr_priority_pick
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] last_owner,
   output logic             valid,
   output logic [SEL_W-1:0] winner
);

   logic [SEL_W-1:0] idx;
   logic             found;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      idx    = '0;
      found  = 1'b0;
      winner = '0;
      // An offset of NREQ truncates to zero, which puts last_owner at the end of the search.
      for (int i = 1; i <= NREQ; i++) begin
         idx = last_owner + SEL_W'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      valid = found;
   end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin owner of the 8-bit internal bus: registered one-hot grant plus mux select.
// Optional forced revoke of a stuck owner is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter_4
   import arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  done,
   output logic [NREQ-1:0]  gnt,
   output logic [SEL_W-1:0] sel,
   output logic             bus_busy,
   output logic             timeout_err
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout_cycles
      $error("bus_arbiter_4: TIMEOUT_CYCLES must lie in 2..256");
   end

   arb_state_t       state_q, state_d;
   logic [SEL_W-1:0] owner_q, owner_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             pick_valid;
   logic [SEL_W-1:0] pick_winner;

   // One picker serves both IDLE and RELEASE; they arbitrate identically.
   rr_priority_pick u_pick (
      .req        (req),
      .last_owner (last_q),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE, RELEASE: begin
            if (pick_valid) begin
               state_d = GRANT;
               owner_d = pick_winner;
               gnt_d   = onehot_of(pick_winner);
               sel_d   = pick_winner;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         GRANT: begin
            // Only the owner's done bit matters; req is ignored while granted.
            if (done[owner_q]) begin
               state_d = RELEASE;
               last_d  = owner_q;
               gnt_d   = '0;
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_LIMIT) begin
               state_d = RELEASE;
               last_d  = owner_q;
               gnt_d   = '0;
               terr_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= SEL_W'(NREQ - 1);
         gnt_q   <= '0;
         sel_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign sel      = sel_q;
   assign bus_busy = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: a cycle table for arbitration and hold
// behaviour, plus hand-written sequences for long grants and the timeout option.
`timescale 1ns/1ps
module tb_bus_arbiter_4;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       bus_busy;
   logic       timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   bus_arbiter_4 #(.TIMEOUT_CYCLES(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .gnt         (gnt),
      .sel         (sel),
      .bus_busy    (bus_busy),
      .timeout_err (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, clock once, sample 1 ns after the edge.
   task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d);
      reset = r;
      req   = q;
      done  = d;
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] d,
                      input logic [3:0] g, input logic [1:0] s, input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.done = d; v.gnt = g; v.sel = s; v.busy = b;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      done  = '0;
      #2;

      //   rst   req      done     -> gnt      sel    busy
      // Single requester, release on first grant cycle, back to IDLE.
      add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1);
      add(1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      // All four requesting: order 0,1,2,3,0 with a RELEASE gap each time.
      add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1);
      add(1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1);
      add(1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1);
      add(1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b1);
      add(1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1);
      add(1'b0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b1);
      add(1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1);
      add(1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b1);
      add(1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1);
      add(1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      // Owner 2 ignores foreign done bits and its own dropped req.
      add(1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1);
      add(1'b0, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1);
      add(1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
      // Reset in the middle of owner 1's grant, then owner 1 again.
      add(1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1);
      add(1'b1, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1);
      add(1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
      // Last owner wins alone, but loses to requester 0 straight out of RELEASE.
      add(1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1);
      add(1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1);
      add(1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1);
      add(1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1);
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("v%0d.gnt", i),  8'(gnt),         8'(vecs[i].gnt));
         check($sformatf("v%0d.sel", i),  8'(sel),         8'(vecs[i].sel));
         check($sformatf("v%0d.busy", i), 8'(bus_busy),    8'(vecs[i].busy));
         check($sformatf("v%0d.terr", i), 8'(timeout_err), 8'h00);
      end

`ifdef ARB_TIMEOUT_EN
      // Owner 0 never releases: four GRANT cycles, then forced RELEASE with one error pulse.
      step(1'b1, 4'b0000, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         check($sformatf("to.hold%0d.gnt", c),  8'(gnt),         8'h01);
         check($sformatf("to.hold%0d.terr", c), 8'(timeout_err), 8'h00);
      end
      step(1'b0, 4'b0011, 4'b0000);
      check("to.revoke.gnt",  8'(gnt),         8'h00);
      check("to.revoke.sel",  8'(sel),         8'h00);
      check("to.revoke.busy", 8'(bus_busy),    8'h01);
      check("to.revoke.terr", 8'(timeout_err), 8'h01);
      step(1'b0, 4'b0011, 4'b0000);
      check("to.next.gnt",  8'(gnt),         8'h02);
      check("to.next.sel",  8'(sel),         8'h01);
      check("to.next.terr", 8'(timeout_err), 8'h00);
      // Owner 1 releases on its fourth cycle: a normal release, no error.
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         check($sformatf("to.h1_%0d.gnt", c), 8'(gnt), 8'h02);
      end
      step(1'b0, 4'b0000, 4'b0010);
      check("to.edge.gnt",  8'(gnt),         8'h00);
      check("to.edge.sel",  8'(sel),         8'h01);
      check("to.edge.terr", 8'(timeout_err), 8'h00);
      step(1'b0, 4'b0000, 4'b0000);
      check("to.edge.idle", 8'(bus_busy),    8'h00);
      check("to.edge.terr2", 8'(timeout_err), 8'h00);
`else
      // Without the timeout a grant is held for as long as the owner wants it.
      step(1'b1, 4'b0000, 4'b0000);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         check($sformatf("long%0d.gnt", c),  8'(gnt),         8'h01);
         check($sformatf("long%0d.terr", c), 8'(timeout_err), 8'h00);
      end
      step(1'b0, 4'b0011, 4'b0001);
      check("long.rel.gnt",  8'(gnt),      8'h00);
      check("long.rel.busy", 8'(bus_busy), 8'h01);
      step(1'b0, 4'b0011, 4'b0000);
      check("long.next.gnt", 8'(gnt), 8'h02);
      check("long.next.sel", 8'(sel), 8'h01);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
